muldiv_seq_ctrl: RTL

//  Multi-cycle sequencer for the RV32M operations (ALU function codes 10000..10111).

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/md_iter_step.sv | 32 +++
 rtl/muldiv_seq_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension op codes, sequencer state encoding, operand signedness helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

    localparam logic [1:0] ALUFN_MD_PREFIX = 2'b10;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_t;

    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational multiply/divide iteration: shift-add (mul) or restoring trial subtract (div).
// Zero latency, no flow control; the caller registers hi/lo every cycle it is active.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (div_mode) begin
            // hi stays below the divisor, so diff[XLEN] is exactly the borrow of the trial subtract
            hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M sequencer: XLEN CALC cycles + FIX, result after XLEN+2 cycles (special cases after 1).
// Accepts only in IDLE; result held in DONE until out_ready; flush/rst abort to IDLE next edge.
module muldiv_seq_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    md_state_t       state;
    md_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opd_q;
    logic            neg_q;
    logic            rem_neg_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] fix_res;

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign out_result = result_q;
    assign accept     = in_valid & in_ready & ~flush;

    always_comb begin
        a_neg   = md_a_signed(in_op) & in_a[XLEN-1];
        b_neg   = md_b_signed(in_op) & in_b[XLEN-1];
        a_mag   = a_neg ? -in_a : in_a;
        b_mag   = b_neg ? -in_b : in_b;
        b_zero  = (in_b == '0);
        ovf     = ~in_op[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
        special = in_op[2] & (b_zero | ovf);
        // in_op[1] distinguishes REM*/DIV* within the divide group
        if (b_zero) special_res = in_op[1] ? in_a : '1;
        else        special_res = in_op[1] ? '0 : in_a;
    end

    md_iter_step #(.XLEN(XLEN)) u_step (
        .div_mode (op_q[2]),
        .hi       (hi_q),
        .lo       (lo_q),
        .operand  (opd_q),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = rem_neg_q ? -hi_q : hi_q;
        case (op_q)
            MD_MUL:                      fix_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             fix_res = quo_s;
            default:                     fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CW'(XLEN-1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state <= state_nxt;
            if (!flush) begin
                case (state)
                    ST_IDLE: if (accept) begin
                        op_q      <= in_op;
                        cnt       <= '0;
                        hi_q      <= '0;
                        // lo holds the multiplier (shifted out) or the dividend (shifted into quotient)
                        lo_q      <= in_op[2] ? a_mag : b_mag;
                        opd_q     <= in_op[2] ? b_mag : a_mag;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (special) result_q <= special_res;
                    end
                    ST_CALC: begin
                        hi_q <= hi_nxt;
                        lo_q <= lo_nxt;
                        cnt  <= cnt + 1'b1;
                    end
                    ST_FIX:  result_q <= fix_res;
                    default: ;
                endcase
            end
        end
    end

endmodule
